// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer.
//   state_t : playback FSM states
//   tone_w  : width of the tone-code field (rest + NUM_TONES codes)
//   note_w  : width of one note-table entry (tone code above duration)
package melody_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PLAY   = 2'd1,
      S_PAUSED = 2'd2
   } state_t;

   function automatic int tone_w(input int num_tones);
      return $clog2(num_tones + 1);
   endfunction

   function automatic int note_w(input int num_tones, input int dur_w);
      return tone_w(num_tones) + dur_w;
   endfunction

endpackage

// File: rtl/melody_sequencer_tone_pwm.sv
// tone_pwm: square-wave audio generator for a one-hot tone.
//   CLK  : system clock
//   RSTN : asynchronous active-low reset
//   TONE : one-hot tone select, all-zero = silence
//   PWM  : audio output, held low while TONE is all-zero
// Higher tone index -> shorter half period -> higher pitch.
module tone_pwm #(
   parameter int NUM_TONES = 8,
   parameter int HALF_MIN  = 119289,
   parameter int HALF_STEP = 17037
)(
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic [NUM_TONES-1:0] TONE,
   output logic                 PWM
);
   localparam int HALF_MAX = HALF_MIN + (NUM_TONES - 1) * HALF_STEP;
   localparam int CW       = $clog2(HALF_MAX + 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_half;
   logic          r_lvl;

   always_comb begin
      w_half = CW'(HALF_MAX);
      for (int i = 0; i < NUM_TONES; i++)
         if (TONE[i]) w_half = CW'(HALF_MAX - i * HALF_STEP);
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_cnt <= '0;
         r_lvl <= 1'b0;
      end else if (TONE == '0) begin
         r_cnt <= '0;
         r_lvl <= 1'b0;
      end else if (r_cnt >= w_half - 1'b1) begin
         r_cnt <= '0;
         r_lvl <= ~r_lvl;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Gate with TONE so a rest silences the output in the same cycle.
   assign PWM = r_lvl & (|TONE);

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a register-based note table as one-hot tones.
//   CLK, RSTN           : clock, asynchronous active-low reset
//   BTN, BTN_s, LEN     : start request, tempo select, melody length
//   STOP, PAUSE, LOOP   : abort, freeze, repeat at end of last note
//   WR_EN/WR_ADDR/WR_DATA : table write port {tone code, duration}, IDLE only
//   TONE, PWM           : one-hot current tone (registered), audio output
//   BUSY, STEP, DONE    : playing/paused, current entry, end-of-melody pulse
module melody_sequencer
   import melody_sequencer_pkg::*;
#(
   parameter int NUM_TONES  = 8,
   parameter int DEPTH      = 16,
   parameter int DUR_W      = 3,
   parameter int BEAT_TICKS = 125000000,
   parameter int FAST_TICKS = 125
)(
   input  logic                                 CLK,
   input  logic                                 RSTN,
   input  logic                                 BTN,
   input  logic                                 BTN_s,
   input  logic                                 STOP,
   input  logic                                 PAUSE,
   input  logic                                 LOOP,
   input  logic [$clog2(DEPTH+1)-1:0]           LEN,
   input  logic                                 WR_EN,
   input  logic [$clog2(DEPTH)-1:0]             WR_ADDR,
   input  logic [note_w(NUM_TONES, DUR_W)-1:0]  WR_DATA,
   output logic [NUM_TONES-1:0]                 TONE,
   output logic                                 PWM,
   output logic                                 BUSY,
   output logic [$clog2(DEPTH)-1:0]             STEP,
   output logic                                 DONE
);
   localparam int TW   = tone_w(NUM_TONES);
   localparam int NW   = TW + DUR_W;
   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = $clog2(DEPTH + 1);
   localparam int MAXT = (BEAT_TICKS > FAST_TICKS) ? BEAT_TICKS : FAST_TICKS;
   localparam int PW   = (MAXT > 1) ? $clog2(MAXT) : 1;

   // Reset asserts asynchronously, releases after two clean edges.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) r_rst_sync <= '0;
      else       r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   state_t          r_state, w_nstate;
   logic [NW-1:0]   r_tbl [DEPTH];
   logic [LW-1:0]   r_len;
   logic [PW-1:0]   r_cmp, r_pre;
   logic [DUR_W-1:0] r_beat;
   logic [AW-1:0]   r_step;
   logic [NUM_TONES-1:0] r_tone;
   logic            r_done;

   logic [NW-1:0]    w_note;
   logic [TW-1:0]    w_code;
   logic [DUR_W-1:0] w_dur, w_dur_m1;
   logic             w_tick, w_adv, w_last, w_start, w_end;

   function automatic logic [NUM_TONES-1:0] tone_dec(input logic [TW-1:0] c);
      tone_dec = '0;
      if (c != '0 && int'(c) <= NUM_TONES) tone_dec = NUM_TONES'(1) << (c - 1'b1);
   endfunction

   assign w_note   = r_tbl[r_step];
   assign w_code   = w_note[NW-1:DUR_W];
   assign w_dur    = w_note[DUR_W-1:0];
   // A zero duration still plays for one beat.
   assign w_dur_m1 = (w_dur == '0) ? '0 : w_dur - 1'b1;
   assign w_tick   = (r_state == S_PLAY) && (r_pre == r_cmp);
   assign w_adv    = w_tick && (r_beat == w_dur_m1);
   assign w_last   = (LW'(r_step) == r_len - 1'b1);
   assign w_start  = (r_state == S_IDLE) && BTN && (LEN != '0);
   assign w_end    = w_adv && w_last && !LOOP;

   // Priority in PLAY: STOP, then melody end, then PAUSE.
   always_comb begin
      w_nstate = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_nstate = S_PLAY;
         S_PLAY: begin
            if (STOP)       w_nstate = S_IDLE;
            else if (w_end) w_nstate = S_IDLE;
            else if (PAUSE) w_nstate = S_PAUSED;
         end
         S_PAUSED: begin
            if (STOP)        w_nstate = S_IDLE;
            else if (!PAUSE) w_nstate = S_PLAY;
         end
         default:  w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= S_IDLE;
      else          r_state <= w_nstate;
   end

   // Counters run on every PLAY cycle (including the one that enters PAUSED)
   // and hold in PAUSED, so paused time never eats into a note.
   always_ff @(posedge CLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_len  <= '0;
         r_cmp  <= '0;
         r_pre  <= '0;
         r_beat <= '0;
         r_step <= '0;
         r_tone <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_PLAY) && !STOP && w_end;
         r_tone <= (r_state == S_PLAY) ? tone_dec(w_code) : '0;
         case (r_state)
            S_IDLE: begin
               r_pre <= '0;
               if (w_start) begin
                  r_len  <= LEN;
                  r_cmp  <= BTN_s ? PW'(FAST_TICKS - 1) : PW'(BEAT_TICKS - 1);
                  r_step <= '0;
                  r_beat <= '0;
               end
            end
            S_PLAY: begin
               if (!STOP) begin
                  r_pre <= w_tick ? '0 : r_pre + 1'b1;
                  if (w_adv) begin
                     r_beat <= '0;
                     r_step <= w_last ? '0 : r_step + 1'b1;
                  end else if (w_tick) begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
      end else if (r_state == S_IDLE && WR_EN) begin
         r_tbl[WR_ADDR] <= WR_DATA;
      end
   end

   tone_pwm #(.NUM_TONES(NUM_TONES)) u_pwm (
      .CLK  (CLK),
      .RSTN (w_rst_n),
      .TONE (r_tone),
      .PWM  (PWM)
   );

   assign TONE = r_tone;
   assign BUSY = (r_state != S_IDLE);
   assign STEP = r_step;
   assign DONE = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;
   localparam int NT = 8, DP = 4, DW = 3, BT = 20, FT = 4;
   localparam int AW = 2, LW = 3, NW = 7;

   logic CLK = 0, RSTN = 0, BTN = 0, BTN_s = 0, STOP = 0, PAUSE = 0, LOOP = 0, WR_EN = 0;
   logic [LW-1:0] LEN = '0;
   logic [AW-1:0] WR_ADDR = '0;
   logic [NW-1:0] WR_DATA = '0;
   logic [NT-1:0] TONE;
   logic PWM, BUSY, DONE;
   logic [AW-1:0] STEP;

   melody_sequencer #(.NUM_TONES(NT), .DEPTH(DP), .DUR_W(DW),
                      .BEAT_TICKS(BT), .FAST_TICKS(FT)) dut (
      .CLK(CLK), .RSTN(RSTN), .BTN(BTN), .BTN_s(BTN_s), .STOP(STOP), .PAUSE(PAUSE),
      .LOOP(LOOP), .LEN(LEN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .TONE(TONE), .PWM(PWM), .BUSY(BUSY), .STEP(STEP), .DONE(DONE));

   always #5 CLK = ~CLK;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a note lasts max(dur,1)*T playing cycles.
   int m_mode = 0;  // 0 idle, 1 play, 2 paused
   int m_step = 0, m_left = 0, m_len = 0, m_T = 0, m_sync = 0;
   int m_tbl [DP];
   logic [NT-1:0] m_tone = '0;
   logic m_done = 1'b0;

   function automatic int durb(input int n);
      return ((n & 7) == 0) ? 1 : (n & 7);
   endfunction
   function automatic logic [NT-1:0] dec(input int n);
      int c;
      c = n >> 3;
      if (c >= 1 && c <= NT) return NT'(1) << (c - 1);
      return '0;
   endfunction
   task automatic m_reset();
      m_mode = 0; m_step = 0; m_left = 0; m_len = 0; m_T = 0;
      m_tone = '0; m_done = 1'b0;
      for (int i = 0; i < DP; i++) m_tbl[i] = 0;
   endtask

   always @(negedge RSTN) begin
      m_sync = 0;
      m_reset();
   end

   always @(posedge CLK) begin
      int pm, ps;
      if (!RSTN) begin
         m_sync = 0; m_reset();
      end else if (m_sync < 2) begin
         m_sync++; m_reset();
      end else begin
         pm = m_mode; ps = m_step;
         m_tone = (pm == 1) ? dec(m_tbl[ps]) : '0;
         m_done = 1'b0;
         if (pm == 0 && WR_EN) m_tbl[WR_ADDR] = int'(WR_DATA);
         case (pm)
            0: if (BTN && LEN != 0) begin
               m_mode = 1; m_len = LEN; m_T = BTN_s ? FT : BT; m_step = 0;
               m_left = durb(m_tbl[0]) * m_T;
            end
            1: if (STOP) m_mode = 0;
               else begin
                  m_left--;
                  if (m_left == 0) begin
                     if (m_step == m_len - 1) begin
                        m_step = 0;
                        if (LOOP) m_left = durb(m_tbl[0]) * m_T;
                        else begin m_mode = 0; m_done = 1'b1; end
                     end else begin
                        m_step++;
                        m_left = durb(m_tbl[m_step]) * m_T;
                     end
                  end
                  if (m_mode == 1 && PAUSE) m_mode = 2;
               end
            default: if (STOP) m_mode = 0; else if (!PAUSE) m_mode = 1;
         endcase
      end
   end

   always @(negedge CLK) begin
      chk("tone", int'(TONE), int'(m_tone));
      chk("busy", int'(BUSY), int'(m_mode != 0));
      chk("step", int'(STEP), m_step);
      chk("done", int'(DONE), int'(m_done));
      if (m_tone == '0) chk("pwm_silent", int'(PWM), 0);
   end

   // Directed-test helpers
   int tr_tone[128], tr_done[128], tr_busy[128], tr_step[128];

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask
   task automatic wr(input int a, input int code, input int dur);
      WR_EN = 1; WR_ADDR = AW'(a); WR_DATA = NW'((code << 3) | (dur & 7));
      cyc(1);
      WR_EN = 0;
   endtask
   task automatic start(input int len, input logic fast);
      LEN = LW'(len); BTN_s = fast; BTN = 1;
      cyc(1);
      BTN = 0;
   endtask
   task automatic capture(input int n, input int p_on, input int p_off,
                          input int w_at, input int l_off);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         tr_tone[i] = TONE; tr_done[i] = DONE; tr_busy[i] = BUSY; tr_step[i] = STEP;
         WR_EN = (i == w_at);
         if (i == w_at) begin WR_ADDR = '0; WR_DATA = NW'((5 << 3) | 1); end
         if (i == p_on)  PAUSE = 1;
         if (i == p_off) PAUSE = 0;
         if (i == l_off) LOOP = 0;
      end
      WR_EN = 0;
   endtask
   function automatic int cnt_tone(input int v, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (tr_tone[i] == v) c++;
      return c;
   endfunction
   function automatic int cnt_done(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) c += tr_done[i];
      return c;
   endfunction
   function automatic int cnt_busy(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) c += tr_busy[i];
      return c;
   endfunction
   function automatic int first_tone(input int v, input int n);
      for (int i = 0; i < n; i++) if (tr_tone[i] == v) return i;
      return -1;
   endfunction
   function automatic int last_tone(input int v, input int n);
      for (int i = n - 1; i >= 0; i--) if (tr_tone[i] == v) return i;
      return -1;
   endfunction
   function automatic int first_done(input int n);
      for (int i = 0; i < n; i++) if (tr_done[i] != 0) return i;
      return -1;
   endfunction

   initial begin
      int f, l, z, w;
      // reset state
      cyc(3);
      chk("rst_tone", int'(TONE), 0);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_step", int'(STEP), 0);
      chk("rst_done", int'(DONE), 0);
      RSTN = 1;
      cyc(3);

      // basic melody, fast tempo, no loop
      wr(0, 1, 1); wr(1, 3, 2); wr(2, 0, 1);
      LOOP = 0;
      start(3, 1);
      capture(24, -1, -1, -1, -1);
      f = first_tone(1, 24);
      chk("t1_run01", cnt_tone(1, 24), 4);
      chk("t1_run04", cnt_tone(4, 24), 8);
      chk("t1_done_cnt", cnt_done(24), 1);
      chk("t1_done_pos", first_done(24) - f, 15);
      chk("t1_busy_end", int'(BUSY), 0);

      // pause mid-note 2 for 10 cycles
      start(3, 1);
      capture(40, 7, 17, -1, -1);
      f = first_tone(4, 40); l = last_tone(4, 40); z = 0;
      for (int i = f; i <= l; i++) if (f >= 0 && tr_tone[i] == 0) z++;
      chk("t2_run04", cnt_tone(4, 40), 8);
      chk("t2_gap", z, 10);
      chk("t2_done_cnt", cnt_done(40), 1);

      // loop, ignored write during play, then loop off
      LOOP = 1;
      start(3, 1);
      capture(80, -1, -1, 10, 40);
      w = -1;
      for (int i = 1; i < 79; i++) if (w < 0 && tr_step[i-1] == 2 && tr_step[i] == 0) w = i;
      chk("t3_wrap_found", int'(w > 0), 1);
      if (w < 0) w = 0;
      chk("t3_wrap_busy", tr_busy[w], 1);
      chk("t3_wrap_tone", tr_tone[w+1], 1);
      chk("t3_done_cnt", cnt_done(80), 1);
      chk("t3_busy_end", tr_busy[79], 0);

      // STOP and BTN together
      start(3, 1);
      cyc(6);
      STOP = 1; BTN = 1;
      cyc(1);
      STOP = 0; BTN = 0;
      chk("t4_stop_busy", int'(BUSY), 0);
      capture(20, -1, -1, -1, -1);
      chk("t4_no_done", cnt_done(20), 0);
      chk("t4_no_restart", cnt_busy(20), 0);
      start(0, 1);
      cyc(2);
      chk("t4_len0_busy", int'(BUSY), 0);

      // dur=0 plays one beat, code 9 is a rest
      wr(0, 2, 0); wr(1, 9, 1);
      start(2, 1);
      capture(16, -1, -1, -1, -1);
      chk("t5_run02", cnt_tone(2, 16), 4);
      chk("t5_others", cnt_tone(2, 16) + cnt_tone(0, 16), 16);
      chk("t5_done_cnt", cnt_done(16), 1);

      // asynchronous reset mid-note
      start(2, 0);
      cyc(5);
      chk("t6_pre_tone", int'(TONE), 2);
      #2 RSTN = 0;
      #1;
      chk("t6_async_tone", int'(TONE), 0);
      chk("t6_async_busy", int'(BUSY), 0);
      cyc(3);
      RSTN = 1;
      cyc(3);
      start(3, 1);
      capture(16, -1, -1, -1, -1);
      chk("t6_tbl_zero", cnt_tone(0, 16), 16);
      chk("t6_playing", tr_busy[2], 1);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         @(negedge CLK);
         WR_EN   = ($urandom % 3) == 0;
         WR_ADDR = AW'($urandom);
         WR_DATA = NW'($urandom);
         BTN     = ($urandom % 8) == 0;
         LEN     = LW'($urandom % 5);
         BTN_s   = ($urandom % 4) != 0;
         LOOP    = ($urandom % 3) == 0;
         if (($urandom % 16) == 0) PAUSE = ~PAUSE;
         STOP    = ($urandom % 64) == 0;
      end
      @(negedge CLK);
      WR_EN = 0; BTN = 0; PAUSE = 0; STOP = 0; LOOP = 0;
      cyc(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter NUM_TONES, default 8, meaning the number of scale tones; tone code 0 is rest, codes 1..NUM_TONES are tones.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of note-table entries.
REQ-003 SHALL have parameter DUR_W, default 3, meaning the width of the per-note duration field in beats.
REQ-004 SHALL have parameter BEAT_TICKS, default 125000000, meaning CLK cycles per beat in normal tempo.
REQ-005 SHALL have parameter FAST_TICKS, default 125, meaning CLK cycles per beat in fast tempo (simulation/test).
REQ-006 SHALL have port CLK  in  1  system clock; one clock domain.
REQ-007 SHALL have port RSTN  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port BTN  in  1  start request, level-sampled each cycle.
REQ-009 SHALL have port BTN_s  in  1  tempo select at start: 1 selects FAST_TICKS, 0 selects BEAT_TICKS.
REQ-010 SHALL have port STOP  in  1  abort playback.
REQ-011 SHALL have port PAUSE  in  1  freeze playback while high.
REQ-012 SHALL have port LOOP  in  1  repeat melody, sampled at end of last note.
REQ-013 SHALL have port LEN  in  clog2(DEPTH+1)  melody length in entries, latched at start.
REQ-014 SHALL have ports WR_EN  in  1, WR_ADDR  in  clog2(DEPTH), and WR_DATA  in  clog2(NUM_TONES+1)+DUR_W, forming the note-table write port; tone code sits in the upper bits and duration in the lower bits.
REQ-015 SHALL have port TONE  out  NUM_TONES  one-hot current tone; all-zero for rest or idle.
REQ-016 SHALL have port PWM  out  1  audio output.
REQ-017 SHALL have ports BUSY  out  1, STEP  out  clog2(DEPTH)  current entry index, and DONE  out  1  one-cycle pulse at melody end.

Function
REQ-018 SHALL implement FSM states IDLE, PLAY, and PAUSED.
REQ-019 In IDLE, BTN=1 with LEN!=0 SHALL latch LEN, latch the beat compare value (per BTN_s minus 1), clear STEP, beat counter, and prescaler, and enter PLAY next cycle; BTN with LEN=0 SHALL be ignored.
REQ-020 The prescaler SHALL count 0..cmp and wrap, and SHALL assert an internal beat tick when equal to cmp; it SHALL be held at 0 in IDLE and frozen in PAUSED.
REQ-021 The note at STEP SHALL last max(dur,1) beats; on the beat tick where the beat count equals max(dur,1)-1, STEP SHALL advance and the beat count SHALL clear.
REQ-022 On advance from STEP=LEN-1: if LOOP=1, STEP SHALL go to 0 and playback SHALL continue without a gap; otherwise the FSM SHALL go to IDLE and DONE SHALL pulse for one cycle.
REQ-023 PLAY with PAUSE=1 SHALL enter PAUSED; PAUSED with PAUSE=0 SHALL return to PLAY; TONE SHALL be all-zero while PAUSED and all counters SHALL be retained.
REQ-024 STOP=1 in PLAY or PAUSED SHALL go to IDLE next cycle with no DONE pulse; STOP SHALL have priority over BTN, PAUSE, and advance in the same cycle.
REQ-025 BTN SHALL be ignored outside IDLE, and BTN_s and LEN changes SHALL have no effect until the next start.
REQ-026 Table writes SHALL take effect only in IDLE and SHALL be ignored otherwise; the table SHALL be register-based, so a write in cycle n is visible in cycle n+1.
REQ-027 TONE SHALL be registered with one cycle of latency from a STEP change: bit (code-1) is set when code is 1..NUM_TONES; codes above NUM_TONES SHALL be treated as rest.
REQ-028 BUSY SHALL be 1 in PLAY and PAUSED.

Reset
REQ-029 RSTN=0 SHALL force IDLE, TONE=0, BUSY=0, DONE=0, STEP=0, zero counters, and a zero note table, asynchronously; reset mid-play SHALL silence the output immediately.
REQ-030 Reset release SHALL be synchronised internally by a two-flop deassertion stage.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and the tone/duration field-width functions derived from NUM_TONES and DUR_W.
REQ-032 The PWM audio generation SHALL be a single sub-module, tone_pwm, that takes CLK, RSTN, and TONE and produces PWM at a silent level for all-zero TONE.

Verification (BEAT_TICKS=20, FAST_TICKS=4, DEPTH=4, NUM_TONES=8)
REQ-033 Table {(1,1),(3,2),(0,1)}, LEN=3, BTN_s=1, LOOP=0, BTN pulse -> TONE=0x01 for 4 cycles, 0x04 for 8, 0x00 for 4; then DONE pulses once and BUSY falls.
REQ-034 Same table with LOOP=1 -> after STEP=2, STEP=0 and TONE=0x01 with no idle cycle; deasserting LOOP -> ends after the current pass.
REQ-035 PAUSE held for 10 cycles mid-note 2 -> TONE=0 for those cycles; the note resumes for exactly its remaining cycles, for a total of 8 cycles of 0x04.
REQ-036 STOP and BTN both asserted mid-play -> IDLE next cycle, no DONE, no restart; BTN with LEN=0 -> BUSY stays 0.
REQ-037 A WR_EN during PLAY to entry 0 -> the table is unchanged on the next loop; an entry with dur=0 plays 1 beat; code 9 -> TONE=0.
REQ-038 RSTN low mid-note -> TONE=0 and BUSY=0 without waiting for a CLK edge; the table reads all-zero afterwards.
